// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module  : config_pkg
// Brief   : Core configuration type plus writeback-path shared types.
// Revision: 1.0
// ============================================================================
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } config_t;

    localparam config_t DEFAULT_CONF = '{XLEN: 32};

    // Writeback entry at the default data width; wider cores build their own.
    typedef struct packed {
        logic [4:0]                   rd;
        logic [DEFAULT_CONF.XLEN-1:0] data;
    } wb_entry_t;

    localparam logic [1:0] WB_SRC_NONE = 2'd0;
    localparam logic [1:0] WB_SRC_ALU  = 2'd1;
    localparam logic [1:0] WB_SRC_LSU  = 2'd2;

endpackage : config_pkg
`default_nettype wire

// File: rtl/core_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : core_wb_fifo
// Brief   : Small synchronous FIFO of writeback entries, async active-low reset.
// Revision: 1.0
// ============================================================================
module core_wb_fifo
    import config_pkg::*;
#(
    parameter type T     = wb_entry_t,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : core_wb_fifo
`default_nettype wire

// File: rtl/core_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : core_wb_arbiter
// Brief   : Merges ALU and buffered LSU results onto the register file write
//           port and keeps the long-latency busy scoreboard.
// Revision: 1.0
// ============================================================================
module core_wb_arbiter
    import config_pkg::*;
#(
    parameter config_t CONF      = DEFAULT_CONF,
    parameter int      BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [CONF.XLEN-1:0]  alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [4:0]            lsu_rd,
    input  logic [CONF.XLEN-1:0]  lsu_data,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [4:0]            issue_rd,
    output logic [31:0]           busy,
    output logic [4:0]            a2,
    output logic [CONF.XLEN-1:0]  wd2,
    output logic                  we2
);

    localparam int XLEN = int'(CONF.XLEN);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t      w_fifo_dout;
    entry_t      w_sel;
    logic [1:0]  w_src;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_xfer;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [31:0] w_busy_nxt;

    assign lsu_ready = !w_fifo_full;
    assign w_xfer    = lsu_valid && lsu_ready;
    assign w_push    = w_xfer && !w_bypass;

    core_wb_fifo #(
        .T     (entry_t),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({lsu_rd, lsu_data}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ALU first, then oldest buffered LSU result, then a same-cycle bypass.
    always_comb begin
        w_src    = WB_SRC_NONE;
        w_sel    = '0;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        if (alu_valid) begin
            w_src = WB_SRC_ALU;
            w_sel = '{rd: alu_rd, data: alu_data};
        end else if (!w_fifo_empty) begin
            w_src = WB_SRC_LSU;
            w_sel = w_fifo_dout;
            w_pop = 1'b1;
        end else if (w_xfer) begin
            w_src    = WB_SRC_LSU;
            w_sel    = '{rd: lsu_rd, data: lsu_data};
            w_bypass = 1'b1;
        end
    end

    // Clear before set so a same-cycle reissue of the register keeps it busy.
    always_comb begin
        w_busy_nxt = busy;
        if (w_src == WB_SRC_LSU) begin
            w_busy_nxt[w_sel.rd] = 1'b0;
        end
        if (issue_valid && issue_long && (issue_rd != 5'd0)) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we2  <= 1'b0;
            a2   <= '0;
            wd2  <= '0;
            busy <= '0;
        end else begin
            we2  <= (w_src != WB_SRC_NONE) && (w_sel.rd != 5'd0);
            busy <= w_busy_nxt;
            if (w_src != WB_SRC_NONE) begin
                a2  <= w_sel.rd;
                wd2 <= w_sel.data;
            end
        end
    end

`ifndef SYNTHESIS
    a_lsu_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (lsu_valid && !lsu_ready) |=> ($stable(lsu_rd) && $stable(lsu_data)));
`endif

endmodule : core_wb_arbiter
`default_nettype wire
